// File: rtl/musa_if_pkg.sv
// Shared types and defaults for the MUSA instruction-fetch stage.
package musa_if_pkg;

  typedef enum logic [2:0] {
    BOOT,
    FETCH,
    WAIT_ACK,
    HOLD,
    HALTED
  } fetch_state_t;

  localparam int          ADDR_W_DEF       = 13;
  localparam int          RESET_VECTOR_DEF = 0;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: jump beats taken branch beats sequential increment.
module pc_next_sel
  import musa_if_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] pc_value,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] next_pc,
  output logic              redirect
);

  always_comb begin
    redirect = jump | branch_taken;
    if (jump)
      next_pc = jump_target;
    else if (branch_taken)
      next_pc = branch_target;
    else
      next_pc = pc_value + ADDR_W'(1);
  end

endmodule

// File: rtl/pc_fetch_controller.sv
// IF-stage sequencer: PC update, imem request/ack handshake, stall/redirect/halt.
// Optional ack timeout with sticky fetch_err is built when FETCH_TIMEOUT_EN is defined.
module pc_fetch_controller
  import musa_if_pkg::*;
#(
  parameter int                ADDR_W       = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEF)
`ifdef FETCH_TIMEOUT_EN
  , parameter int              TIMEOUT_CYCLES = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_value,
  output logic              pc_write,
  output logic [ADDR_W-1:0] pc_next,
  input  logic              stall,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt,
  input  logic              resume,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              flush
`ifdef FETCH_TIMEOUT_EN
  , output logic            fetch_err
`endif
);

  fetch_state_t      state;
  logic              drop;
  logic              halt_pending;
  logic [ADDR_W-1:0] sel_pc;
  logic              redirect;
  logic [ADDR_W-1:0] fetch_addr;
  logic              resume_ok;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;
  assign resume_ok = resume & ~halt & ~fetch_err;
`else
  assign resume_ok = resume & ~halt;
`endif

  pc_next_sel #(.ADDR_W(ADDR_W)) u_pc_next_sel (
    .pc_value      (pc_value),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .next_pc       (sel_pc),
    .redirect      (redirect)
  );

  // pc_write/pc_next are registered, so the PC register lags them by a cycle;
  // forward the pending value so FETCH never requests a stale address.
  assign fetch_addr = pc_write ? pc_next : pc_value;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= BOOT;
      pc_write     <= 1'b0;
      pc_next      <= RESET_VECTOR;
      imem_req     <= 1'b0;
      imem_addr    <= '0;
      if_valid     <= 1'b0;
      if_instr     <= NOP_INSTR;
      if_pc        <= '0;
      flush        <= 1'b0;
      drop         <= 1'b0;
      halt_pending <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      fetch_err    <= 1'b0;
      tmo_cnt      <= '0;
`endif
    end else begin
      pc_write <= 1'b0;
      flush    <= 1'b0;
      if (!stall) if_valid <= 1'b0;
      if (halt && state != BOOT) halt_pending <= 1'b1;

      // Redirects act in every active state, regardless of stall.
      if (redirect && (state == FETCH || state == WAIT_ACK || state == HOLD)) begin
        pc_write <= 1'b1;
        pc_next  <= sel_pc;
        flush    <= 1'b1;
        if_valid <= 1'b0;
      end

      case (state)
        BOOT: begin
          pc_write <= 1'b1;
          pc_next  <= RESET_VECTOR;
          state    <= FETCH;
        end
        FETCH: begin
          if (halt_pending) begin
            state <= HALTED;
          end else begin
            imem_req  <= 1'b1;
            imem_addr <= fetch_addr;
            drop      <= redirect;
            state     <= WAIT_ACK;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
          end
        end
        WAIT_ACK: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            drop     <= 1'b0;
            state    <= FETCH;
            if (!drop && !redirect) begin
              if_instr <= imem_rdata;
              if_pc    <= imem_addr;
              if_valid <= 1'b1;
              if (stall) begin
                state <= HOLD;
              end else begin
                pc_write <= 1'b1;
                pc_next  <= sel_pc;
              end
            end
          end else begin
            if (redirect) drop <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
              imem_req  <= 1'b0;
              fetch_err <= 1'b1;
              drop      <= 1'b0;
              state     <= HALTED;
            end else begin
              tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
`endif
          end
        end
        HOLD: begin
          if (redirect) begin
            state <= FETCH;
          end else if (!stall) begin
            pc_write <= 1'b1;
            pc_next  <= sel_pc;
            state    <= FETCH;
          end
        end
        HALTED: begin
          if (resume_ok) begin
            halt_pending <= 1'b0;
            state        <= FETCH;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Directed bench for pc_fetch_controller with a behavioural PC register.
module tb_pc_fetch_controller;

  localparam int AW = 13;

  logic          clk;
  logic          reset;
  logic [AW-1:0] pc_value;
  logic          pc_write;
  logic [AW-1:0] pc_next;
  logic          stall;
  logic          jump;
  logic [AW-1:0] jump_target;
  logic          branch_taken;
  logic [AW-1:0] branch_target;
  logic          halt;
  logic          resume;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic          if_valid;
  logic [31:0]   if_instr;
  logic [AW-1:0] if_pc;
  logic          flush;
`ifdef FETCH_TIMEOUT_EN
  logic          fetch_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pc_fetch_controller dut (
    .clk           (clk),
    .reset         (reset),
    .pc_value      (pc_value),
    .pc_write      (pc_write),
    .pc_next       (pc_next),
    .stall         (stall),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt          (halt),
    .resume        (resume),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .flush         (flush)
`ifdef FETCH_TIMEOUT_EN
    , .fetch_err   (fetch_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ProgramCounter register model
  always @(posedge clk or negedge reset) begin
    if (!reset) pc_value <= '0;
    else if (pc_write) pc_value <= pc_next;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int budget, output bit ok);
    for (int i = 0; i < budget && !imem_req; i++) step();
    ok = imem_req;
  endtask

  // Completes the outstanding request one wait cycle later.
  task automatic serve(input logic [31:0] data);
    step();
    imem_ack = 1'b1; imem_rdata = data;
    step();
    imem_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(); step();
    n_tests++; if ({pc_write, imem_req, if_valid, flush} !== 4'b0000) begin n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {pc_write, imem_req, if_valid, flush}); end
    n_tests++; if (pc_next !== 13'h0000) begin n_fail++; $display("FAIL reset_pc_next: got %h want 0000", pc_next); end
    n_tests++; if ({imem_addr, if_pc, if_instr} !== {13'h0, 13'h0, 32'h0}) begin n_fail++; $display("FAIL reset_data: got %h/%h/%h want 0/0/0", imem_addr, if_pc, if_instr); end
`ifdef FETCH_TIMEOUT_EN
    n_tests++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_err: got %b want 0", fetch_err); end
`endif
    reset = 1'b1;
  endtask

  task automatic test_sequential();
    bit ok;
    logic [31:0] data;
    step();
    n_tests++; if ({pc_write, pc_next} !== {1'b1, 13'h0000}) begin n_fail++; $display("FAIL boot_pc: got %b/%h want 1/0000", pc_write, pc_next); end
    for (int k = 0; k < 3; k++) begin
      wait_req(4, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL seq_req_timeout: got req=%b want 1", imem_req); end
      n_tests++; if (imem_addr !== AW'(k)) begin n_fail++; $display("FAIL seq_addr: got %h want %h", imem_addr, AW'(k)); end
      data = 32'hA000_0001 + 32'(k);
      serve(data);
      n_tests++; if ({if_valid, if_pc, if_instr} !== {1'b1, AW'(k), data}) begin n_fail++; $display("FAIL seq_deliver: got %b/%h/%h want 1/%h/%h", if_valid, if_pc, if_instr, AW'(k), data); end
      n_tests++; if ({pc_write, pc_next, imem_req} !== {1'b1, AW'(k + 1), 1'b0}) begin n_fail++; $display("FAIL seq_pc_write: got %b/%h/%b want 1/%h/0", pc_write, pc_next, imem_req, AW'(k + 1)); end
      step();
      n_tests++; if ({pc_write, if_valid, imem_req} !== 3'b001) begin n_fail++; $display("FAIL seq_pulse: got %b want 001", {pc_write, if_valid, imem_req}); end
    end
  endtask

  task automatic test_stall();
    n_tests++; if ({imem_req, imem_addr} !== {1'b1, 13'h0003}) begin n_fail++; $display("FAIL stall_req: got %b/%h want 1/0003", imem_req, imem_addr); end
    step();
    imem_ack = 1'b1; imem_rdata = 32'hA000_0004; stall = 1'b1;
    step();
    imem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_tests++; if ({if_valid, if_pc, if_instr, pc_write, imem_req} !== {1'b1, 13'h0003, 32'hA000_0004, 1'b0, 1'b0}) begin n_fail++; $display("FAIL stall_hold: got %b/%h/%h/%b/%b want 1/0003/a0000004/0/0", if_valid, if_pc, if_instr, pc_write, imem_req); end
      step();
    end
    stall = 1'b0;
    step();
    n_tests++; if ({pc_write, pc_next, if_valid} !== {1'b1, 13'h0004, 1'b0}) begin n_fail++; $display("FAIL stall_release: got %b/%h/%b want 1/0004/0", pc_write, pc_next, if_valid); end
    step();
    n_tests++; if ({imem_req, imem_addr} !== {1'b1, 13'h0004}) begin n_fail++; $display("FAIL stall_next_req: got %b/%h want 1/0004", imem_req, imem_addr); end
  endtask

  task automatic test_branch();
    serve(32'hA000_0005);
    step();
    n_tests++; if ({imem_req, imem_addr} !== {1'b1, 13'h0005}) begin n_fail++; $display("FAIL br_req5: got %b/%h want 1/0005", imem_req, imem_addr); end
    branch_taken = 1'b1; branch_target = 13'h0040;
    step();
    branch_taken = 1'b0;
    n_tests++; if ({flush, pc_write, pc_next} !== {1'b1, 1'b1, 13'h0040}) begin n_fail++; $display("FAIL br_redirect: got %b/%b/%h want 1/1/0040", flush, pc_write, pc_next); end
    step();
    n_tests++; if ({flush, imem_req} !== 2'b01) begin n_fail++; $display("FAIL br_flush_pulse: got %b want 01", {flush, imem_req}); end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_0005;
    step();
    imem_ack = 1'b0;
    n_tests++; if ({if_valid, pc_write, imem_req} !== 3'b000) begin n_fail++; $display("FAIL br_drop: got %b want 000", {if_valid, pc_write, imem_req}); end
    step();
    n_tests++; if ({imem_req, imem_addr, if_valid} !== {1'b1, 13'h0040, 1'b0}) begin n_fail++; $display("FAIL br_target_req: got %b/%h/%b want 1/0040/0", imem_req, imem_addr, if_valid); end
  endtask

  task automatic test_priority();
    jump = 1'b1; jump_target = 13'h0100; branch_taken = 1'b1; branch_target = 13'h0200;
    step();
    jump = 1'b0; branch_taken = 1'b0;
    n_tests++; if ({flush, pc_next} !== {1'b1, 13'h0100}) begin n_fail++; $display("FAIL prio_jump: got %b/%h want 1/0100", flush, pc_next); end
    serve(32'hDEAD_0040);
    n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL prio_drop: got %b want 0", if_valid); end
    step();
    n_tests++; if ({imem_req, imem_addr} !== {1'b1, 13'h0100}) begin n_fail++; $display("FAIL prio_req: got %b/%h want 1/0100", imem_req, imem_addr); end
  endtask

  task automatic test_wrap();
    jump = 1'b1; jump_target = 13'h1FFF;
    step();
    jump = 1'b0;
    serve(32'hDEAD_0100);
    step();
    n_tests++; if ({imem_req, imem_addr} !== {1'b1, 13'h1FFF}) begin n_fail++; $display("FAIL wrap_req: got %b/%h want 1/1fff", imem_req, imem_addr); end
    serve(32'hA000_1FFF);
    n_tests++; if ({pc_write, pc_next, if_valid, if_pc} !== {1'b1, 13'h0000, 1'b1, 13'h1FFF}) begin n_fail++; $display("FAIL wrap_pc: got %b/%h/%b/%h want 1/0000/1/1fff", pc_write, pc_next, if_valid, if_pc); end
    step();
    n_tests++; if ({imem_req, imem_addr} !== {1'b1, 13'h0000}) begin n_fail++; $display("FAIL wrap_next_req: got %b/%h want 1/0000", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_with_ack();
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0000; jump = 1'b1; jump_target = 13'h0010;
    step();
    imem_ack = 1'b0; jump = 1'b0;
    n_tests++; if ({flush, pc_next, if_valid, imem_req} !== {1'b1, 13'h0010, 1'b0, 1'b0}) begin n_fail++; $display("FAIL rda_redirect: got %b/%h/%b/%b want 1/0010/0/0", flush, pc_next, if_valid, imem_req); end
    step();
    n_tests++; if ({imem_req, imem_addr} !== {1'b1, 13'h0010}) begin n_fail++; $display("FAIL rda_req: got %b/%h want 1/0010", imem_req, imem_addr); end
  endtask

  task automatic test_halt();
    halt = 1'b1;
    step();
    halt = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hA000_0010;
    step();
    imem_ack = 1'b0;
    n_tests++; if ({if_valid, if_pc, if_instr, pc_next} !== {1'b1, 13'h0010, 32'hA000_0010, 13'h0011}) begin n_fail++; $display("FAIL halt_deliver: got %b/%h/%h/%h want 1/0010/a0000010/0011", if_valid, if_pc, if_instr, pc_next); end
    for (int i = 0; i < 4; i++) step();
    n_tests++; if ({imem_req, pc_write, if_valid} !== 3'b000) begin n_fail++; $display("FAIL halt_idle: got %b want 000", {imem_req, pc_write, if_valid}); end
    resume = 1'b1;
    step();
    resume = 1'b0;
    step();
    n_tests++; if ({imem_req, imem_addr} !== {1'b1, 13'h0011}) begin n_fail++; $display("FAIL halt_resume: got %b/%h want 1/0011", imem_req, imem_addr); end
    halt = 1'b1;
    step();
    halt = 1'b0;
    serve(32'hA000_0011);
    step();
    halt = 1'b1; resume = 1'b1;
    step();
    halt = 1'b0; resume = 1'b0;
    step(); step();
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL halt_and_resume: got req=%b want 0", imem_req); end
    resume = 1'b1;
    step();
    resume = 1'b0;
    step();
    n_tests++; if ({imem_req, imem_addr} !== {1'b1, 13'h0012}) begin n_fail++; $display("FAIL halt_resume2: got %b/%h want 1/0012", imem_req, imem_addr); end
  endtask

  task automatic test_no_ack();
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 15; i++) step();
    n_tests++; if ({imem_req, fetch_err} !== 2'b10) begin n_fail++; $display("FAIL tmo_before: got %b want 10", {imem_req, fetch_err}); end
    step();
    n_tests++; if ({imem_req, fetch_err} !== 2'b01) begin n_fail++; $display("FAIL tmo_fire: got %b want 01", {imem_req, fetch_err}); end
    resume = 1'b1;
    step();
    resume = 1'b0;
    step();
    n_tests++; if ({imem_req, fetch_err} !== 2'b01) begin n_fail++; $display("FAIL tmo_resume_ignored: got %b want 01", {imem_req, fetch_err}); end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_0012;
    step();
    imem_ack = 1'b0;
    n_tests++; if ({if_valid, pc_write} !== 2'b00) begin n_fail++; $display("FAIL tmo_late_ack: got %b want 00", {if_valid, pc_write}); end
`else
    for (int i = 0; i < 20; i++) step();
    n_tests++; if ({imem_req, imem_addr, if_valid} !== {1'b1, 13'h0012, 1'b0}) begin n_fail++; $display("FAIL wait_forever: got %b/%h/%b want 1/0012/0", imem_req, imem_addr, if_valid); end
`endif
  endtask

  task automatic test_reset_mid();
    reset = 1'b0;
    #2;
    n_tests++; if ({imem_req, pc_write, if_valid, pc_next} !== {3'b000, 13'h0000}) begin n_fail++; $display("FAIL async_reset: got %b/%h want 000/0000", {imem_req, pc_write, if_valid}, pc_next); end
`ifdef FETCH_TIMEOUT_EN
    n_tests++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL async_reset_err: got %b want 0", fetch_err); end
`endif
    step();
    reset = 1'b1;
    step();
    n_tests++; if ({pc_write, pc_next} !== {1'b1, 13'h0000}) begin n_fail++; $display("FAIL reboot: got %b/%h want 1/0000", pc_write, pc_next); end
    step();
    n_tests++; if ({imem_req, imem_addr} !== {1'b1, 13'h0000}) begin n_fail++; $display("FAIL reboot_req: got %b/%h want 1/0000", imem_req, imem_addr); end
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; jump = 1'b0; jump_target = '0;
    branch_taken = 1'b0; branch_target = '0; halt = 1'b0; resume = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0;
    #1;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_priority();
    test_wrap();
    test_redirect_with_ack();
    test_halt();
    test_no_ack();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/pc_fetch_controller.md
Name: pc_fetch_controller

Overview:
Sequencer for the MUSA IF stage. It drives the ProgramCounter write enable and next value, and runs the instruction-memory request/ack handshake. It also applies stall, branch/jump redirect and halt/resume, then presents fetched instructions to the IF/ID boundary. It sits between the hazard/branch logic in ID/EX, the PC register and instruction memory.

Parameters:
ADDR_W, 13, PC and instruction-memory word-address width.
RESET_VECTOR, 0, first fetch address after reset.
TIMEOUT_CYCLES, 16, ack timeout limit; used only with FETCH_TIMEOUT_EN.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
pc_value  in  ADDR_W  current ProgramCounter output.
pc_write  out  1  ProgramCounter write enable.
pc_next  out  ADDR_W  ProgramCounter input value.
stall  in  1  hazard-unit stall; IF/ID must hold.
jump  in  1  jump redirect request.
jump_target  in  ADDR_W  jump destination.
branch_taken  in  1  taken-branch redirect request.
branch_target  in  ADDR_W  branch destination.
halt  in  1  HALT decoded.
resume  in  1  leave halted state.
imem_req  out  1  instruction-memory request.
imem_addr  out  ADDR_W  request address.
imem_ack  in  1  data valid this cycle.
imem_rdata  in  32  instruction word.
if_valid  out  1  if_instr/if_pc valid to ID.
if_instr  out  32  fetched instruction.
if_pc  out  ADDR_W  address of if_instr.
flush  out  1  one-cycle pulse: kill ID contents.
fetch_err  out  1  present only with FETCH_TIMEOUT_EN.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state BOOT; pc_write 0; pc_next RESET_VECTOR; imem_req 0; imem_addr 0; if_valid 0; if_instr 0; if_pc 0; flush 0; drop flag 0; halt_pending 0; fetch_err 0.
- BOOT: pc_write=1 and pc_next=RESET_VECTOR for one cycle, then FETCH.
- FETCH: imem_req=1, imem_addr=pc_value (registered). Next state WAIT_ACK. If halt_pending, go HALTED instead and issue no request.
- WAIT_ACK: imem_req and imem_addr are held until imem_ack.
  - On ack with drop=0 and stall=0: capture if_instr/if_pc; if_valid=1 next cycle; pc_write=1; pc_next=pc_value+1 (mod 2^ADDR_W, 0x1FFF wraps to 0x0000); go FETCH.
  - On ack with drop=0 and stall=1: capture the instruction and go HOLD; no pc_write.
  - On ack with drop=1: discard data; clear drop; go FETCH; no pc_write.
- HOLD: if_valid stays 1 with contents frozen. When stall=0: pc_write=1, pc_next=pc_value+1, go FETCH.
- if_valid falls the cycle after the instruction is consumed (stall=0) unless a new one is captured.
- Redirect (sampled in FETCH, WAIT_ACK, HOLD; ignored in BOOT/HALTED):
  - Priority: jump > branch_taken > sequential.
  - That cycle: pc_write=1, pc_next=target, flush=1 for one cycle, if_valid=0 next cycle.
  - Any outstanding or same-cycle-issued request sets drop=1.
  - Redirect in HOLD discards the held instruction and goes FETCH.
  - Redirect together with ack: redirect wins and the data is dropped.
  - Redirect is applied even while stall=1.
- Halt: halt sets halt_pending in any state except BOOT. The outstanding request completes normally; entry to HALTED happens at the next FETCH. A same-cycle redirect is applied first.
- HALTED: imem_req=0, pc_write=0; if_valid drops after consumption. resume=1 clears halt_pending and goes FETCH. halt and resume together keep the block HALTED.
- Reset mid-transaction: immediate return to reset values; imem_req drops asynchronously.

Optional Feature:
FETCH_TIMEOUT_EN.
- Defined: a counter runs in WAIT_ACK. When it reaches TIMEOUT_CYCLES without ack:
  - imem_req=0;
  - fetch_err=1, sticky until reset;
  - state goes HALTED and resume is ignored while fetch_err=1.
  - A late ack is ignored.
- Undefined: no counter and no fetch_err port; WAIT_ACK waits indefinitely.

Decomposition:
- Package musa_if_pkg: fetch state enum (BOOT, FETCH, WAIT_ACK, HOLD, HALTED); ADDR_W default; RESET_VECTOR default; NOP encoding.
- Sub-module pc_next_sel (combinational): jump/branch/increment priority mux producing pc_next and the redirect flag.

Test Plan:
- Release reset, ack 2 cycles after each req, data 0xA0000001.. → imem_addr 0,1,2; if_pc 0,1,2 with matching data; pc_write pulses once per ack.
- stall=1 on the ack for addr 3, held 4 cycles → if_valid=1 with if_pc=3 frozen; no pc_write until stall falls; then next req addr 4.
- branch_taken with target 0x040 during WAIT_ACK for addr 5 → flush pulse, pc_next=0x040; addr-5 data never shown; next req addr 0x040.
- jump=1 (0x100) and branch_taken=1 (0x200) together → pc_next=0x100.
- pc_value=0x1FFF with ack → pc_next=0x0000.
- halt during WAIT_ACK → that instruction is delivered, then imem_req=0; resume → fetch continues at the next address. With FETCH_TIMEOUT_EN and no ack for 16 cycles → fetch_err=1, HALTED, resume ignored.
